// File: rtl/bram_writer.sv
// Stream-to-BRAM loader: writes DEPTH bytes from a valid/ready stream to addresses 0..DEPTH-1,
// takes a trailing checksum byte, reads the region back and reports pass/fail.
module bram_writer #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              bram_we,
    output logic              bram_re,
    input  logic [7:0]        bram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_CHK, S_VERIFY, S_DONE} state_t;

    localparam logic [ADDR_W:0] CNT_LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [ADDR_W:0]   rcnt_q, rcnt_d;
    logic [ADDR_W:0]   rtn_q, rtn_d;
    logic              rd_vld_q, rd_vld_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        chk_q, chk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [7:0]        total;

    assign total = sum_q + chk_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            rtn_q    <= '0;
            rd_vld_q <= 1'b0;
            sum_q    <= '0;
            chk_q    <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            rtn_q    <= rtn_d;
            rd_vld_q <= rd_vld_d;
            sum_q    <= sum_d;
            chk_q    <= chk_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            re_q     <= re_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        rtn_d    = rtn_q;
        rd_vld_d = re_q;
        sum_d    = sum_q;
        chk_d    = chk_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WRITE;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    rtn_d   = '0;
                    sum_d   = '0;
                end
            end
            S_WRITE: begin
                if (s_valid) begin
                    we_d   = 1'b1;
                    addr_d = wcnt_q[ADDR_W-1:0];
                    din_d  = s_data;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == CNT_LAST) state_d = S_CHK;
                end
            end
            S_CHK: begin
                // The checksum beat also launches the read of address 0,
                // so rcnt counts reads already issued.
                if (s_valid) begin
                    chk_d   = s_data;
                    state_d = S_VERIFY;
                    re_d    = 1'b1;
                    addr_d  = '0;
                    rcnt_d  = (ADDR_W+1)'(1);
                end
            end
            S_VERIFY: begin
                if (rcnt_q != CNT_DEPTH) begin
                    re_d   = 1'b1;
                    addr_d = rcnt_q[ADDR_W-1:0];
                    rcnt_d = rcnt_q + 1'b1;
                end
                if (rd_vld_q) begin
                    sum_d = sum_q + bram_dout;
                    rtn_d = rtn_q + 1'b1;
                end else if (rtn_q == CNT_DEPTH) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (total == 8'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_ready   = (state_q == S_WRITE) || (state_q == S_CHK);
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign bram_we   = we_q;
    assign bram_re   = re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule
